// File: rtl/mvm_engine_if.sv
// Handshake and data bundle between mvm_engine and its requester / weight memory.
// The master side issues start, supplies vectors and weights; the slave (engine) returns results.
interface mvm_engine_if #(
  parameter int NROW     = 16,
  parameter int NCOL     = 8,
  parameter int BITWIDTH = 18
);
  localparam int ADDR_BITWIDTH = (NCOL > 1) ? $clog2(NCOL) : 1;

  logic                     start;
  logic [NCOL*BITWIDTH-1:0] input_vec;
  logic [NROW*BITWIDTH-1:0] bias_vec;
  logic [NROW*BITWIDTH-1:0] weight_mem_output;
  logic [ADDR_BITWIDTH-1:0] col_address;
  logic                     busy;
  logic                     data_ready;
  logic [NROW*BITWIDTH-1:0] output_vec;

  modport master (
    output start, input_vec, bias_vec, weight_mem_output,
    input  col_address, busy, data_ready, output_vec
  );

  modport slave (
    input  start, input_vec, bias_vec, weight_mem_output,
    output col_address, busy, data_ready, output_vec
  );
endinterface

// File: rtl/mvm_engine.sv
// Fixed-point matrix-vector multiply y = W*x + b, one weight column per cycle from a
// registered-read memory; full-precision accumulate, then bias, round-half-up and saturate/wrap.
module mvm_engine #(
  parameter int NROW     = 16,
  parameter int NCOL     = 8,
  parameter int QN       = 6,
  parameter int QM       = 11,
  parameter int SATURATE = 1
) (
  input logic            i_clk,
  input logic            i_rst,
  mvm_engine_if.slave    io_bus
);
  localparam int BITWIDTH      = QN + QM + 1;
  localparam int ADDR_BITWIDTH = (NCOL > 1) ? $clog2(NCOL) : 1;
  localparam int ACC_BITWIDTH  = 2 * BITWIDTH + $clog2(NCOL) + 1;
  localparam int SUM_BITWIDTH  = ACC_BITWIDTH + 1;

  localparam logic [ADDR_BITWIDTH-1:0] LastCol = ADDR_BITWIDTH'(NCOL - 1);
  localparam logic signed [SUM_BITWIDTH-1:0] RoundConst = SUM_BITWIDTH'(1) <<< (QM - 1);
  localparam logic signed [SUM_BITWIDTH-1:0] MaxVal =
    (SUM_BITWIDTH'(1) <<< (BITWIDTH - 1)) - SUM_BITWIDTH'(1);
  localparam logic signed [SUM_BITWIDTH-1:0] MinVal = -(SUM_BITWIDTH'(1) <<< (BITWIDTH - 1));

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StFinish} state_t;

  state_t                           r_state;
  logic [ADDR_BITWIDTH-1:0]         r_col;
  logic [ADDR_BITWIDTH-1:0]         r_mem_col;
  logic                             r_mem_vld;
  logic                             r_busy;
  logic                             r_data_ready;
  logic [NROW*BITWIDTH-1:0]         r_out;
  logic [NCOL*BITWIDTH-1:0]         r_x;
  logic [NROW*BITWIDTH-1:0]         r_b;
  logic signed [ACC_BITWIDTH-1:0]   r_acc [NROW];

  logic signed [BITWIDTH-1:0]       w_x_sel;
  logic signed [2*BITWIDTH-1:0]     w_prod     [NROW];
  logic signed [ACC_BITWIDTH-1:0]   w_acc_next [NROW];
  logic signed [SUM_BITWIDTH-1:0]   w_sum      [NROW];
  logic signed [SUM_BITWIDTH-1:0]   w_shift    [NROW];
  logic [NROW*BITWIDTH-1:0]         w_result;

  always_comb begin
    // r_mem_col names the column currently presented by the weight memory
    w_x_sel  = $signed(r_x[int'(r_mem_col)*BITWIDTH +: BITWIDTH]);
    w_result = '0;
    for (int r = 0; r < NROW; r++) begin
      w_prod[r]     = (2*BITWIDTH)'($signed(io_bus.weight_mem_output[r*BITWIDTH +: BITWIDTH])) *
                      (2*BITWIDTH)'(w_x_sel);
      w_acc_next[r] = r_acc[r] + ACC_BITWIDTH'(w_prod[r]);
      w_sum[r]      = SUM_BITWIDTH'(r_acc[r]) +
                      (SUM_BITWIDTH'($signed(r_b[r*BITWIDTH +: BITWIDTH])) <<< QM) + RoundConst;
      w_shift[r]    = w_sum[r] >>> QM;
      if ((SATURATE != 0) && (w_shift[r] > MaxVal)) begin
        w_result[r*BITWIDTH +: BITWIDTH] = MaxVal[BITWIDTH-1:0];
      end else if ((SATURATE != 0) && (w_shift[r] < MinVal)) begin
        w_result[r*BITWIDTH +: BITWIDTH] = MinVal[BITWIDTH-1:0];
      end else begin
        w_result[r*BITWIDTH +: BITWIDTH] = w_shift[r][BITWIDTH-1:0];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= StIdle;
      r_col        <= '0;
      r_mem_col    <= '0;
      r_mem_vld    <= 1'b0;
      r_busy       <= 1'b0;
      r_data_ready <= 1'b0;
      r_out        <= '0;
      r_x          <= '0;
      r_b          <= '0;
      for (int r = 0; r < NROW; r++) r_acc[r] <= '0;
    end else begin
      r_data_ready <= 1'b0;
      if (r_mem_vld) begin
        for (int r = 0; r < NROW; r++) r_acc[r] <= w_acc_next[r];
      end
      unique case (r_state)
        StIdle: begin
          r_col <= '0;
          if (io_bus.start) begin
            r_x     <= io_bus.input_vec;
            r_b     <= io_bus.bias_vec;
            r_busy  <= 1'b1;
            r_state <= StIssue;
            for (int r = 0; r < NROW; r++) r_acc[r] <= '0;
          end else begin
            r_busy <= 1'b0;
          end
        end
        StIssue: begin
          r_mem_vld <= 1'b1;
          r_mem_col <= r_col;
          if (r_col == LastCol) begin
            r_state <= StDrain;
          end else begin
            r_col <= r_col + 1'b1;
          end
        end
        StDrain: begin
          r_mem_vld <= 1'b0;
          r_state   <= StFinish;
        end
        StFinish: begin
          r_out        <= w_result;
          r_data_ready <= 1'b1;
          r_col        <= '0;
          r_state      <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign io_bus.col_address = r_col;
  assign io_bus.busy        = r_busy;
  assign io_bus.data_ready  = r_data_ready;
  assign io_bus.output_vec  = r_out;
endmodule

// File: tb/tb_mvm_engine.sv
// Bench for mvm_engine: saturating and wrapping instances share stimulus; results are
// checked against a longint reference model through per-instance scoreboard queues.
module tb_mvm_engine;
  localparam int NROW = 16;
  localparam int NCOL = 8;
  localparam int QN   = 6;
  localparam int QM   = 11;
  localparam int BW   = QN + QM + 1;
  localparam int VW   = NROW * BW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  always #5 clk = ~clk;

  logic signed [BW-1:0] w_mat [NROW][NCOL];
  logic signed [BW-1:0] x_arr [NCOL];
  logic signed [BW-1:0] b_arr [NROW];
  logic [NCOL*BW-1:0]   x_packed;
  logic [VW-1:0]        b_packed;

  always_comb begin
    x_packed = '0;
    b_packed = '0;
    for (int c = 0; c < NCOL; c++) x_packed[c*BW +: BW] = x_arr[c];
    for (int r = 0; r < NROW; r++) b_packed[r*BW +: BW] = b_arr[r];
  end

  mvm_engine_if #(.NROW(NROW), .NCOL(NCOL), .BITWIDTH(BW)) bus_s ();
  mvm_engine_if #(.NROW(NROW), .NCOL(NCOL), .BITWIDTH(BW)) bus_w ();

  assign bus_s.start     = start;
  assign bus_s.input_vec = x_packed;
  assign bus_s.bias_vec  = b_packed;
  assign bus_w.start     = start;
  assign bus_w.input_vec = x_packed;
  assign bus_w.bias_vec  = b_packed;

  // Registered-read weight memories, one per instance
  always @(posedge clk) begin
    for (int r = 0; r < NROW; r++) begin
      bus_s.weight_mem_output[r*BW +: BW] <= w_mat[r][bus_s.col_address];
      bus_w.weight_mem_output[r*BW +: BW] <= w_mat[r][bus_w.col_address];
    end
  end

  mvm_engine #(.NROW(NROW), .NCOL(NCOL), .QN(QN), .QM(QM), .SATURATE(1)) u_dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus_s)
  );

  mvm_engine #(.NROW(NROW), .NCOL(NCOL), .QN(QN), .QM(QM), .SATURATE(0)) u_dut_wrap (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus_w)
  );

  int checks = 0;
  int errors = 0;
  logic [VW-1:0] q_sat  [$];
  logic [VW-1:0] q_wrap [$];

  function automatic logic [VW-1:0] model(input bit sat);
    logic [VW-1:0] res;
    longint acc;
    longint s;
    longint hi;
    longint lo;
    res = '0;
    hi  = (longint'(1) << (BW - 1)) - 1;
    lo  = -(longint'(1) << (BW - 1));
    for (int r = 0; r < NROW; r++) begin
      acc = 0;
      for (int c = 0; c < NCOL; c++) acc += longint'(w_mat[r][c]) * longint'(x_arr[c]);
      s = acc + longint'(b_arr[r]) * (longint'(1) << QM) + (longint'(1) << (QM - 1));
      s = s >>> QM;
      if (sat && s > hi) s = hi;
      if (sat && s < lo) s = lo;
      res[r*BW +: BW] = s[BW-1:0];
    end
    return res;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_uniform(input int w, input int x, input int b);
    for (int r = 0; r < NROW; r++) begin
      b_arr[r] = BW'(b);
      for (int c = 0; c < NCOL; c++) w_mat[r][c] = BW'(w);
    end
    for (int c = 0; c < NCOL; c++) x_arr[c] = BW'(x);
  endtask

  task automatic push_expected();
    q_sat.push_back(model(1'b1));
    q_wrap.push_back(model(1'b0));
  endtask

  task automatic run_job(input string tag);
    int lat;
    push_expected();
    @(negedge clk);
    start = 1'b1;
    lat = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 0) start = 1'b0;
      if (bus_s.data_ready === 1'b1) begin
        lat = k;
        break;
      end
    end
    check({tag, "_latency"}, 64'(lat), 64'(NCOL + 2));
  endtask

  // Scoreboard: every data_ready must match the oldest pending expectation
  always @(negedge clk) begin
    if (bus_s.data_ready === 1'b1) begin
      checks++;
      assert (q_sat.size() != 0) else begin
        errors++;
        $error("FAIL sb_sat_unexpected: observed data_ready=1 expected no result pending");
      end
      if (q_sat.size() != 0) begin
        logic [VW-1:0] exp_s;
        exp_s = q_sat.pop_front();
        checks++;
        assert (bus_s.output_vec === exp_s) else begin
          errors++;
          $error("FAIL sb_sat: observed %0h expected %0h", bus_s.output_vec, exp_s);
        end
      end
    end
    if (bus_w.data_ready === 1'b1) begin
      checks++;
      assert (q_wrap.size() != 0) else begin
        errors++;
        $error("FAIL sb_wrap_unexpected: observed data_ready=1 expected no result pending");
      end
      if (q_wrap.size() != 0) begin
        logic [VW-1:0] exp_w;
        exp_w = q_wrap.pop_front();
        checks++;
        assert (bus_w.output_vec === exp_w) else begin
          errors++;
          $error("FAIL sb_wrap: observed %0h expected %0h", bus_w.output_vec, exp_w);
        end
      end
    end
  end

  initial begin
    int dr1;
    int dr2;
    set_uniform(0, 0, 0);
    repeat (2) @(negedge clk);
    check("rst_col", 64'(bus_s.col_address), 0);
    check("rst_busy", 64'(bus_s.busy), 0);
    check("rst_ready", 64'(bus_s.data_ready), 0);
    check("rst_out", 64'(bus_s.output_vec[63:0]), 0);
    check("rst_out_wrap", 64'(bus_w.output_vec[63:0]), 0);
    rst = 1'b0;

    // Test 1: all ones, cycle-by-cycle address / busy / ready timing
    set_uniform(2048, 2048, 0);
    push_expected();
    @(negedge clk);
    start = 1'b1;
    for (int k = 0; k <= 12; k++) begin
      @(negedge clk);
      if (k == 0) start = 1'b0;
      check($sformatf("t1_col_%0d", k), 64'(bus_s.col_address),
            64'((k <= 7) ? k : ((k <= 9) ? 7 : 0)));
      check($sformatf("t1_busy_%0d", k), 64'(bus_s.busy), 64'(k <= 10));
      check($sformatf("t1_ready_%0d", k), 64'(bus_s.data_ready), 64'(k == 10));
    end
    check("t1_row5", 64'(bus_s.output_vec[5*BW +: BW]), 64'(16384));

    // Test 2: bias and row-distinct weights
    set_uniform(2048, 2048, -4096);
    run_job("bias");
    check("bias_row0", 64'(bus_s.output_vec[BW-1:0]), 64'(12288));
    set_uniform(0, 2048, 0);
    for (int r = 0; r < NROW; r++)
      for (int c = 0; c < NCOL; c++) w_mat[r][c] = BW'(r * 2048);
    run_job("rowdist");
    check("rowdist_row3", 64'(bus_s.output_vec[3*BW +: BW]), 64'(3 * 16384));

    // Test 3: saturation / wrap
    set_uniform(61440, 61440, 0);
    run_job("sat_pos");
    check("sat_pos_row0", 64'(bus_s.output_vec[BW-1:0]), 64'(131071));
    check("wrap_pos_row0", 64'(bus_w.output_vec[BW-1:0]), 64'(65536));
    set_uniform(61440, -61440, 0);
    run_job("sat_neg");
    check("sat_neg_row0", 64'(bus_s.output_vec[BW-1:0]), 64'(18'h20000));
    check("wrap_neg_row0", 64'(bus_w.output_vec[BW-1:0]), 64'(196608));

    // Test 4: rounding
    set_uniform(0, 0, 0);
    for (int r = 0; r < NROW; r++) w_mat[r][0] = BW'(1024);
    x_arr[0] = BW'(1);
    run_job("round_pos");
    check("round_pos_row0", 64'(bus_s.output_vec[BW-1:0]), 64'(1));
    x_arr[0] = BW'(-1);
    run_job("round_neg");
    check("round_neg_row0", 64'(bus_s.output_vec[BW-1:0]), 64'(0));
    for (int r = 0; r < NROW; r++) w_mat[r][0] = BW'(512);
    x_arr[0] = BW'(1);
    run_job("round_qtr");
    check("round_qtr_row0", 64'(bus_s.output_vec[BW-1:0]), 64'(0));

    // Test 5: start held high -> back-to-back; input change after acceptance ignored
    set_uniform(2048, 2048, 1024);
    push_expected();
    push_expected();
    dr1 = -1;
    dr2 = -1;
    @(negedge clk);
    start = 1'b1;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (k == 11) start = 1'b0;
      if (k == 13) for (int c = 0; c < NCOL; c++) x_arr[c] = '0;
      if (bus_s.data_ready === 1'b1) begin
        if (dr1 < 0) dr1 = k;
        else dr2 = k;
      end
    end
    check("b2b_first", 64'(dr1), 64'(NCOL + 2));
    check("b2b_second", 64'(dr2), 64'(2 * NCOL + 5));
    check("b2b_row0", 64'(bus_s.output_vec[BW-1:0]), 64'(17408));

    // Test 6: asynchronous reset mid-operation
    set_uniform(2048, 2048, 0);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("arst_out", 64'(bus_s.output_vec[BW-1:0]), 0);
    check("arst_busy", 64'(bus_s.busy), 0);
    check("arst_col", 64'(bus_s.col_address), 0);
    check("arst_ready", 64'(bus_s.data_ready), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("arst_no_ready", 64'(bus_s.data_ready), 0);
    run_job("post_rst");
    check("post_rst_row7", 64'(bus_s.output_vec[7*BW +: BW]), 64'(16384));

    repeat (3) @(negedge clk);
    check("sb_sat_drained", 64'(q_sat.size()), 0);
    check("sb_wrap_drained", 64'(q_wrap.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
